// File: rtl/cmd_chk_pkg.sv
// Shared types and constants for the RemoteComm command/response checker.
// State encoding, verdict codes and the calibrate command/response pair.
package cmd_chk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_SNT,
    WAIT_RESP,
    CHK_PULSE,
    FINISH
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISMATCH = 2'd1,
    ERR_TIMEOUT  = 2'd2,
    ERR_PULSE    = 2'd3
  } err_e;

  localparam logic [15:0] CAL_CMD  = 16'h0000;
  localparam logic [7:0]  CAL_RESP = 8'hA5;

endpackage

// File: rtl/cmd_chk_fifo.sv
// DEPTH x W command queue with wrap-around pointers and a registered count.
// full/empty derive from the count, so a push at full is refused even alongside a pop.
module cmd_chk_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 24
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [W-1:0]               i_wdata,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [W-1:0]               o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_wr_en;
  logic          w_rd_en;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  // A flush wins over any concurrent push or pop.
  assign w_wr_en = i_push && !o_full && !i_flush;
  assign w_rd_en = i_pop && !o_empty && !i_flush;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cmd_resp_checker.sv
// Replays queued commands to RemoteComm and checks each response, timeout and pulse width.
// Optional macro HALT_ON_FAIL_EN: stop at the first failure, flush the queue and finish.
module cmd_resp_checker
  import cmd_chk_pkg::*;
#(
  parameter int CMD_W   = 16,
  parameter int RESP_W  = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 500000,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [CMD_W-1:0]  push_cmd,
  input  logic [RESP_W-1:0] push_exp,
  output logic              full,
  input  logic              start,
  output logic [CMD_W-1:0]  cmd,
  output logic              snd_cmd,
  input  logic              cmd_snt,
  input  logic              resp_rdy,
  input  logic [RESP_W-1:0] resp,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic [1:0]        last_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

`ifdef HALT_ON_FAIL_EN
  localparam bit HALT_ON_FAIL = 1'b1;
`else
  localparam bit HALT_ON_FAIL = 1'b0;
`endif

  state_e              r_state;
  state_e              w_state_next;
  logic [TW-1:0]       r_timer;
  logic [CMD_W-1:0]    r_cmd;
  logic                r_mis;
  logic [CNT_W-1:0]    r_pass;
  logic [CNT_W-1:0]    r_fail;
  err_e                r_err;

  logic [CMD_W+RESP_W-1:0] w_head;
  logic [CMD_W-1:0]    w_head_cmd;
  logic [RESP_W-1:0]   w_head_exp;
  logic                w_full;
  logic                w_empty;
  logic [AW:0]         w_count;
  logic                w_pop;
  logic                w_flush;
  logic                w_last;
  logic                w_timeout;
  logic                w_verdict_en;
  err_e                w_verdict_code;

  cmd_chk_fifo #(
    .DEPTH (DEPTH),
    .W     (CMD_W + RESP_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (push),
    .i_wdata ({push_cmd, push_exp}),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign {w_head_cmd, w_head_exp} = w_head;

  // Queue drains with this pop unless a push lands in the same cycle.
  assign w_last    = (w_count == (AW+1)'(1)) && !(push && !w_full);
  assign w_timeout = (r_timer == TW'(TIMEOUT - 1));

  always_comb begin
    w_state_next   = r_state;
    w_verdict_en   = 1'b0;
    w_verdict_code = ERR_NONE;
    w_pop          = 1'b0;
    w_flush        = 1'b0;
    case (r_state)
      IDLE: if (start) w_state_next = w_empty ? FINISH : SEND;
      SEND: w_state_next = WAIT_SNT;
      WAIT_SNT: begin
        if (w_timeout) begin
          w_verdict_en   = 1'b1;
          w_verdict_code = ERR_TIMEOUT;
        end else if (cmd_snt) begin
          w_state_next = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (resp_rdy) begin
          w_state_next = CHK_PULSE;
        end else if (w_timeout) begin
          w_verdict_en   = 1'b1;
          w_verdict_code = ERR_TIMEOUT;
        end
      end
      CHK_PULSE: begin
        w_verdict_en = 1'b1;
        if (r_mis)         w_verdict_code = ERR_MISMATCH;
        else if (resp_rdy) w_verdict_code = ERR_PULSE;
      end
      FINISH:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    if (w_verdict_en) begin
      w_pop        = 1'b1;
      w_state_next = w_last ? FINISH : SEND;
      if (HALT_ON_FAIL && (w_verdict_code != ERR_NONE)) begin
        w_flush      = 1'b1;
        w_state_next = FINISH;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_cmd   <= '0;
      r_mis   <= 1'b0;
      r_pass  <= '0;
      r_fail  <= '0;
      r_err   <= ERR_NONE;
    end else begin
      r_state <= w_state_next;
      if (r_state == SEND) begin
        r_timer <= '0;
        r_cmd   <= w_head_cmd;
      end else if (r_state == WAIT_SNT || r_state == WAIT_RESP) begin
        r_timer <= r_timer + 1'b1;
      end
      if (r_state == WAIT_RESP && resp_rdy) begin
        r_mis <= (resp != w_head_exp);
      end
      // Counters saturate rather than wrap.
      if (r_state == IDLE && start) begin
        r_pass <= '0;
        r_fail <= '0;
        r_err  <= ERR_NONE;
      end else if (w_verdict_en) begin
        if (w_verdict_code == ERR_NONE) begin
          if (r_pass != '1) r_pass <= r_pass + 1'b1;
        end else begin
          if (r_fail != '1) r_fail <= r_fail + 1'b1;
          r_err <= w_verdict_code;
        end
      end
    end
  end

  // The head is driven straight out during SEND so cmd is valid with the strobe.
  assign cmd      = (r_state == SEND) ? w_head_cmd : r_cmd;
  assign snd_cmd  = (r_state == SEND);
  assign busy     = (r_state != IDLE);
  assign done     = (r_state == FINISH);
  assign full     = w_full;
  assign pass_cnt = r_pass;
  assign fail_cnt = r_fail;
  assign last_err = r_err;

endmodule
